// File: rtl/neopixel_pkg.sv
// rtl/neopixel_pkg.sv - shared types, widths and timing helper for the neopixel receiver
// Purpose: decoder state enum, colour/counter widths and the ns-to-cycles conversion.
// Ports: none (package).
package neopixel_pkg;

    localparam int COLOR_W = 24;
    localparam int CNT_W   = 16;
    localparam int IDX_W   = 5;

    typedef enum logic [2:0] {
        ST_GAP,
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_PASS
    } state_t;

    // floor(clk_hz * ns / 1e9), done in 64 bits so large products do not overflow
    function automatic int unsigned ns_to_cycles(input longint unsigned clk_hz,
                                                 input longint unsigned ns);
        longint unsigned prod;
        prod = (clk_hz * ns) / 64'd1_000_000_000;
        return 32'(prod);
    endfunction

endpackage

// File: rtl/neopixel_rx_sync_edge.sv
// rtl/neopixel_rx_sync_edge.sv - two-flop synchronizer with edge detection
// Purpose: brings the asynchronous serial line into the CLK domain and flags its edges.
// Ports:
//   CLK     in  : clock, rising edge
//   reset_n in  : asynchronous active-low reset
//   din     in  : asynchronous serial input
//   level   out : synchronized line level
//   rise    out : one-cycle pulse on a synchronized rising edge
//   fall    out : one-cycle pulse on a synchronized falling edge
module sync_edge (
    input  logic CLK,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], din};
            r_prev <= r_sync[1];
        end
    end

    assign level = r_sync[1];
    assign rise  = r_sync[1] & ~r_prev;
    assign fall  = ~r_sync[1] & r_prev;

endmodule

// File: rtl/neopixel_rx.sv
// rtl/neopixel_rx.sv - WS2812-style one-wire colour word receiver
// Purpose: decodes 24-bit MSB-first words from pulse-width coded one-wire data,
//          detects the latch gap and protocol errors. Optional forwarding of
//          downstream words is enabled with the macro NEOPIXEL_RX_FWD_EN.
// Ports:
//   CLK         in  : clock, rising edge
//   reset_n     in  : asynchronous active-low reset
//   one_wire    in  : serial data, asynchronous to CLK
//   color       out : last complete word, first-received bit in [23]
//   color_valid out : one-cycle pulse when color updates
//   latch       out : one-cycle pulse when a reset gap ends a frame
//   err         out : one-cycle pulse on a protocol error
//   dout        out : daisy-chain output (NEOPIXEL_RX_FWD_EN only)
module neopixel_rx
    import neopixel_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 32_000_000,
    parameter int unsigned T_THRESH_NS = 600,
    parameter int unsigned T_MAXH_NS   = 2000,
    parameter int unsigned T_RESET_NS  = 50000
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic               one_wire,
    output logic [COLOR_W-1:0] color,
    output logic               color_valid,
    output logic               latch,
    output logic               err
`ifdef NEOPIXEL_RX_FWD_EN
    ,
    output logic               dout
`endif
);

    localparam logic [CNT_W-1:0] C_THRESH = CNT_W'(ns_to_cycles(64'(CLK_HZ), 64'(T_THRESH_NS)));
    localparam logic [CNT_W-1:0] C_MAXH   = CNT_W'(ns_to_cycles(64'(CLK_HZ), 64'(T_MAXH_NS)));
    localparam logic [CNT_W-1:0] C_RST    = CNT_W'(ns_to_cycles(64'(CLK_HZ), 64'(T_RESET_NS)));
    localparam logic [IDX_W-1:0] C_LAST   = IDX_W'(COLOR_W - 1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    logic w_level;
    logic w_rise;
    logic w_fall;

    sync_edge u_sync_edge (
        .CLK     (CLK),
        .reset_n (reset_n),
        .din     (one_wire),
        .level   (w_level),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    state_t               r_state;
    logic [CNT_W-1:0]     r_count;
    logic [IDX_W-1:0]     r_idx;
    logic [COLOR_W-2:0]   r_shift;
    logic [COLOR_W-1:0]   r_color;
    logic                 r_color_valid;
    logic                 r_latch;
    logic                 r_err;
    logic                 r_pend;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [COLOR_W-2:0]   w_shift_nxt;
    logic [COLOR_W-1:0]   w_color_nxt;
    logic                 w_cv_nxt;
    logic                 w_latch_nxt;
    logic                 w_err_nxt;
    logic                 w_pend_nxt;

    logic [CNT_W-1:0]     w_count_inc;
    logic [CNT_W-1:0]     w_low_cnt;
    logic [CNT_W-1:0]     w_gap_cnt;
    logic                 w_gap_done;
    logic                 w_bit;

    // Saturating increment so a line parked low for a long time never wraps.
    assign w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + C_ONE;
    // Consecutive-low counter: restarts whenever the line is high.
    assign w_low_cnt   = w_level ? '0 : w_count_inc;
    // r_count holds the low cycles already elapsed, so the gap completes even
    // if the line rises in this very cycle; that edge is then carried by r_pend.
    assign w_gap_done  = (r_count >= C_RST);
    // When the gap completes on a rising edge, this cycle is the first high one.
    assign w_gap_cnt   = {{(CNT_W-1){1'b0}}, w_rise};
    // r_count equals the number of high cycles seen before the falling edge.
    assign w_bit       = (r_count >= C_THRESH);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_GAP;
            r_count       <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_color       <= '0;
            r_color_valid <= 1'b0;
            r_latch       <= 1'b0;
            r_err         <= 1'b0;
            r_pend        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_idx         <= w_idx_nxt;
            r_shift       <= w_shift_nxt;
            r_color       <= w_color_nxt;
            r_color_valid <= w_cv_nxt;
            r_latch       <= w_latch_nxt;
            r_err         <= w_err_nxt;
            r_pend        <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_color_nxt = r_color;
        w_cv_nxt    = 1'b0;
        w_latch_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_pend_nxt  = 1'b0;

        case (r_state)
            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = ST_IDLE;
                    w_pend_nxt  = w_rise;
                    w_count_nxt = w_gap_cnt;
                end else begin
                    w_count_nxt = w_low_cnt;
                end
            end

            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                    w_count_nxt = C_ONE;
                end else if (r_pend) begin
                    // Edge arrived on the gap-completion cycle; one high cycle already counted.
                    w_state_nxt = ST_HIGH;
                    w_count_nxt = w_count_inc;
                end
            end

            ST_HIGH: begin
                if (w_fall) begin
                    w_count_nxt = C_ONE;
                    w_shift_nxt = {r_shift[COLOR_W-3:0], w_bit};
                    if (r_idx == C_LAST) begin
                        w_color_nxt = {r_shift, w_bit};
                        w_cv_nxt    = 1'b1;
                        w_state_nxt = ST_PASS;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = ST_LOW;
                    end
                end else if (r_count > C_MAXH) begin
                    w_err_nxt   = 1'b1;
                    w_idx_nxt   = '0;
                    w_count_nxt = '0;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_count_nxt = w_count_inc;
                end
            end

            ST_LOW: begin
                if (w_gap_done) begin
                    // A gap inside a word: drop the partial word without latching.
                    w_err_nxt   = (r_idx != '0);
                    w_idx_nxt   = '0;
                    w_pend_nxt  = w_rise;
                    w_count_nxt = w_gap_cnt;
                    w_state_nxt = ST_IDLE;
                end else if (w_rise) begin
                    w_count_nxt = C_ONE;
                    w_state_nxt = ST_HIGH;
                end else begin
                    w_count_nxt = w_count_inc;
                end
            end

            ST_PASS: begin
                if (w_gap_done) begin
                    w_latch_nxt = 1'b1;
                    w_idx_nxt   = '0;
                    w_pend_nxt  = w_rise;
                    w_count_nxt = w_gap_cnt;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_count_nxt = w_low_cnt;
                end
            end

            default: begin
                w_state_nxt = ST_GAP;
                w_count_nxt = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign color       = r_color;
    assign color_valid = r_color_valid;
    assign latch       = r_latch;
    assign err         = r_err;

`ifdef NEOPIXEL_RX_FWD_EN
    // Relay the synchronized line only while downstream words are passing.
    assign dout = (r_state == ST_PASS) & w_level;
`endif

endmodule
